// File: rtl/roulette_pkg.sv
// roulette_pkg: shared state encodings, opcodes and payout multipliers for the roulette round logic
package roulette_pkg;
    localparam logic [2:0] BETTING     = 3'd0;
    localparam logic [2:0] SPIN        = 3'd1;
    localparam logic [2:0] WAIT_RESULT = 3'd2;
    localparam logic [2:0] SETTLE      = 3'd3;
    localparam logic [2:0] DONE        = 3'd4;

    localparam logic [5:0] OP_SPIN = 6'b111110;
    localparam logic [5:0] OP_NONE = 6'b111111;
    localparam logic [5:0] OP_EVEN = 6'd40;
    localparam logic [5:0] OP_ODD  = 6'd41;

    localparam logic [7:0] STRAIGHT_MULT = 8'd36;
    localparam logic [7:0] EVEN_MULT     = 8'd2;
endpackage

// File: rtl/roulette_payout_calc.sv
// roulette_payout_calc: chips returned for one bet byte {stake, opcode} against a winning number
module roulette_payout_calc
    import roulette_pkg::*;
(
    input  logic [7:0] bet,
    input  logic [5:0] result,
    output logic [7:0] amount
);
    logic [7:0] stake;
    logic [5:0] op;
    logic       on_wheel;

    always_comb begin
        stake    = {6'd0, bet[7:6]};
        op       = bet[5:0];
        on_wheel = result <= 6'd36;
        amount   = !on_wheel                                      ? 8'd0 :
                   (op == result)                                 ? STRAIGHT_MULT * stake :
                   (op == OP_EVEN && result != 6'd0 && !result[0]) ? EVEN_MULT * stake :
                   (op == OP_ODD && result[0])                    ? EVEN_MULT * stake : 8'd0;
    end
endmodule

// File: rtl/roulette_round_ctrl.sv
// roulette_round_ctrl: collects bets, gates the wheel spin, captures the result and walks the
// bet buffer emitting one registered payout record per cycle
module roulette_round_ctrl
    import roulette_pkg::*;
#(
    parameter int MAX_BETS        = 12,
    parameter int SPIN_MIN_CYCLES = 1024,
    parameter int RESULT_TIMEOUT  = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bet_valid,
    input  logic [7:0] bet_data,
    output logic       bet_ready,
    input  logic       spin_req,
    output logic       spin_active,
    input  logic       result_valid,
    input  logic [5:0] result_number,
    output logic       payout_valid,
    output logic [3:0] payout_index,
    output logic [7:0] payout_amount,
    output logic       round_done,
    output logic       round_abort,
    output logic [3:0] bet_count,
    output logic [2:0] state_dbg
);
    localparam int CW = $clog2((SPIN_MIN_CYCLES > RESULT_TIMEOUT ? SPIN_MIN_CYCLES : RESULT_TIMEOUT) + 1);
    localparam logic [3:0] MAXB = 4'(MAX_BETS);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [5:0]    result;
    logic          aborted;
    logic [7:0]    bets [16];
    logic [7:0]    amount;
    logic          store;

    roulette_payout_calc u_calc (
        .bet    (bets[idx]),
        .result (result),
        .amount (amount)
    );

    always_comb begin
        bet_ready   = state == BETTING && bet_count < MAXB;
        store       = bet_valid && bet_ready && bet_data[7:6] != 2'd0 && bet_data[5:0] != OP_NONE;
        spin_active = state == SPIN || state == WAIT_RESULT;
        round_done  = state == DONE;
        round_abort = round_done && aborted;
        state_dbg   = state;
    end

    always_ff @(posedge clock) begin
        if (store)
            bets[bet_count] <= bet_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= BETTING;
            bet_count     <= 4'd0;
            cnt           <= '0;
            idx           <= 4'd0;
            result        <= 6'd0;
            aborted       <= 1'b0;
            payout_valid  <= 1'b0;
            payout_index  <= 4'd0;
            payout_amount <= 8'd0;
        end else begin
            payout_valid <= 1'b0;
            case (state)
                BETTING: begin
                    if (store)
                        bet_count <= bet_count + 4'd1;
                    // a bet arriving with the spin request still joins this round
                    if (spin_req && (bet_count != 4'd0 || store)) begin
                        state <= SPIN;
                        cnt   <= '0;
                    end
                end
                SPIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SPIN_MIN_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= WAIT_RESULT;
                    end
                end
                WAIT_RESULT: begin
                    cnt <= cnt + 1'b1;
                    if (result_valid) begin
                        result <= result_number;
                        idx    <= 4'd0;
                        state  <= SETTLE;
                    end else if (cnt == CW'(RESULT_TIMEOUT - 1)) begin
                        aborted <= 1'b1;
                        state   <= DONE;
                    end
                end
                SETTLE: begin
                    if (idx == bet_count) begin
                        state <= DONE;
                    end else begin
                        payout_valid  <= 1'b1;
                        payout_index  <= idx;
                        payout_amount <= amount;
                        idx           <= idx + 4'd1;
                    end
                end
                DONE: begin
                    bet_count <= 4'd0;
                    aborted   <= 1'b0;
                    state     <= BETTING;
                end
                default: state <= BETTING;
            endcase
        end
    end
endmodule

// File: tb/tb_roulette_round_ctrl.sv
// tb_roulette_round_ctrl: directed and randomized rounds checked every cycle against a
// round-timeline model built from bet lists and cycle offsets
module tb_roulette_round_ctrl;
    localparam int S  = 20;
    localparam int T  = 50;
    localparam int MB = 12;

    logic       clock = 1'b0;
    logic       reset;
    logic       bet_valid;
    logic [7:0] bet_data;
    logic       bet_ready;
    logic       spin_req;
    logic       spin_active;
    logic       result_valid;
    logic [5:0] result_number;
    logic       payout_valid;
    logic [3:0] payout_index;
    logic [7:0] payout_amount;
    logic       round_done;
    logic       round_abort;
    logic [3:0] bet_count;
    logic [2:0] state_dbg;

    roulette_round_ctrl #(.MAX_BETS(MB), .SPIN_MIN_CYCLES(S), .RESULT_TIMEOUT(T)) dut (
        .clock         (clock),
        .reset         (reset),
        .bet_valid     (bet_valid),
        .bet_data      (bet_data),
        .bet_ready     (bet_ready),
        .spin_req      (spin_req),
        .spin_active   (spin_active),
        .result_valid  (result_valid),
        .result_number (result_number),
        .payout_valid  (payout_valid),
        .payout_index  (payout_index),
        .payout_amount (payout_amount),
        .round_done    (round_done),
        .round_abort   (round_abort),
        .bet_count     (bet_count),
        .state_dbg     (state_dbg)
    );

    always #5 clock = ~clock;

    int n_chk, n_fail, cyc, done_cnt, abort_cnt;
    int rec_idx[$], rec_amt[$], rec_cyc[$];
    logic [7:0] q[$];
    int k, r, resn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int pay(input logic [7:0] b, input int res);
        int s, op;
        s  = int'(b[7:6]);
        op = int'(b[5:0]);
        if (res > 36) return 0;
        if (op <= 36) return (op == res) ? 36 * s : 0;
        if (op == 40) return (res != 0 && res % 2 == 0) ? 2 * s : 0;
        if (op == 41) return (res % 2 == 1) ? 2 * s : 0;
        return 0;
    endfunction

    // k counts cycles since the spin was accepted (0 = betting); r is the k at which the result arrived
    task automatic monitor();
        int n, pi, e_cnt;
        logic e_ready, e_sa, e_pv, e_done, e_abort;
        logic [2:0] e_st;
        forever begin
            @(negedge clock);
            cyc++;
            n = q.size();
            e_ready = 0; e_sa = 0; e_pv = 0; e_done = 0; e_abort = 0; e_st = 0; e_cnt = n; pi = 0;
            if (!reset) begin
                q.delete(); k = 0; r = 0; e_ready = 1; e_cnt = 0;
            end else if (k == 0) begin
                e_ready = n < MB;
            end else if (k <= S) begin
                e_st = 1; e_sa = 1;
            end else if (r == 0 && k <= S + T) begin
                e_st = 2; e_sa = 1;
            end else if (r == 0) begin
                e_st = 4; e_done = 1; e_abort = 1;
            end else if (k <= r + n + 1) begin
                e_st = 3; e_pv = k >= r + 2; pi = k - r - 2;
            end else begin
                e_st = 4; e_done = 1;
            end
            chk("bet_ready", 32'(bet_ready), 32'(e_ready));
            chk("spin_active", 32'(spin_active), 32'(e_sa));
            chk("payout_valid", 32'(payout_valid), 32'(e_pv));
            chk("round_done", 32'(round_done), 32'(e_done));
            chk("round_abort", 32'(round_abort), 32'(e_abort));
            chk("bet_count", 32'(bet_count), 32'(e_cnt));
            chk("state_dbg", 32'(state_dbg), 32'(e_st));
            if (e_pv) begin
                chk("payout_index", 32'(payout_index), 32'(pi));
                chk("payout_amount", 32'(payout_amount), 32'(pay(q[pi], resn)));
            end
            if (payout_valid === 1'b1) begin
                rec_idx.push_back(int'(payout_index));
                rec_amt.push_back(int'(payout_amount));
                rec_cyc.push_back(cyc);
            end
            if (round_done === 1'b1) done_cnt++;
            if (round_abort === 1'b1) abort_cnt++;
            if (reset) begin
                if (k == 0) begin
                    if (bet_valid && n < MB && bet_data[7:6] != 2'd0 && bet_data[5:0] != 6'h3F)
                        q.push_back(bet_data);
                    if (spin_req && q.size() > 0) k = 1;
                end else if (e_done) begin
                    k = 0; r = 0; q.delete();
                end else begin
                    if (r == 0 && k > S && result_valid) begin
                        r = k; resn = int'(result_number);
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [7:0] b);
        bet_valid = 1'b1;
        bet_data  = b;
        tick();
        bet_valid = 1'b0;
    endtask

    task automatic spin();
        spin_req = 1'b1;
        tick();
        spin_req = 1'b0;
    endtask

    task automatic give_result(input int d, input int num);
        repeat (S + d) tick();
        result_valid  = 1'b1;
        result_number = 6'(num);
        tick();
        result_valid = 1'b0;
    endtask

    task automatic wait_done(output int t);
        t = 0;
        while (round_done !== 1'b1 && t < 1000) begin
            tick();
            t++;
        end
        chk("done_seen", 32'(round_done), 32'd1);
        tick();
    endtask

    task automatic rand_round();
        int nb, cls, t, w;
        bit conc, tmo;
        logic [7:0] b;
        nb   = $urandom_range(1, 5);
        conc = 1'($urandom_range(0, 1));
        tmo  = $urandom_range(0, 4) == 0;
        for (int i = 0; i < nb; i++) begin
            cls = $urandom_range(0, 3);
            b[5:0] = cls == 0 ? 6'($urandom_range(0, 36)) : cls == 1 ? 6'd40 :
                     cls == 2 ? 6'd41 : 6'($urandom_range(37, 63));
            b[7:6] = (i == 0) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            if (i == 0 && b[5:0] == 6'h3F) b[5:0] = 6'd0;
            repeat ($urandom_range(0, 2)) tick();
            if (conc && i == nb - 1) begin
                spin_req = 1'b1;
                offer(b);
                spin_req = 1'b0;
            end else begin
                offer(b);
            end
        end
        if (!conc) spin();
        for (int i = 0; i < S; i++) begin
            if (i == 3) begin
                result_valid  = 1'b1;
                result_number = 6'($urandom_range(0, 36));
            end
            spin_req  = i == 5;
            bet_valid = i == 7;
            bet_data  = 8'h45;
            tick();
            result_valid = 1'b0;
            spin_req     = 1'b0;
            bet_valid    = 1'b0;
        end
        if (tmo) begin
            wait_done(t);
            chk("rand_timeout_lat", 32'(t), 32'(T));
        end else begin
            w = $urandom_range(0, 10);
            repeat (w) tick();
            result_valid  = 1'b1;
            result_number = 6'($urandom_range(0, 40));
            tick();
            result_valid = 1'b0;
            wait_done(t);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, t, dc, ac, w;
        int e1[3];
        e1 = '{0, 72, 6};
        reset = 1'b0; bet_valid = 1'b0; bet_data = 8'd0; spin_req = 1'b0;
        result_valid = 1'b0; result_number = 6'd0;
        n_chk = 0; n_fail = 0; cyc = 0; done_cnt = 0; abort_cnt = 0; k = 0; r = 0; resn = 0;
        fork monitor(); join_none
        repeat (3) tick();
        chk("rst_ready", 32'(bet_ready), 32'd1);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_payout_valid", 32'(payout_valid), 32'd0);
        chk("rst_count", 32'(bet_count), 32'd0);
        reset = 1'b1;
        tick();
        chk("model_pay_straight", 32'(pay(8'h8A, 10)), 32'd72);
        chk("model_pay_even_zero", 32'(pay(8'h68, 0)), 32'd0);

        base = rec_idx.size();
        offer(8'h45); offer(8'h8A); offer(8'hE8);
        spin();
        give_result(0, 10);
        wait_done(t);
        chk("t1_records", 32'(rec_idx.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_index", 32'(rec_idx[base + i]), 32'(i));
            chk("t1_amount", 32'(rec_amt[base + i]), 32'(e1[i]));
            chk("t1_consecutive", 32'(rec_cyc[base + i] - rec_cyc[base]), 32'(i));
        end
        chk("t1_count_cleared", 32'(bet_count), 32'd0);

        base = rec_idx.size();
        for (int i = 0; i < 14; i++) begin
            chk("full_ready", 32'(bet_ready), 32'(i < MB));
            offer({2'(1 + i % 3), 6'(i)});
        end
        chk("full_count", 32'(bet_count), 32'd12);
        chk("full_ready_low", 32'(bet_ready), 32'd0);
        spin();
        give_result(2, 7);
        wait_done(t);
        chk("full_records", 32'(rec_idx.size() - base), 32'd12);

        spin();
        chk("empty_spin_state", 32'(state_dbg), 32'd0);
        chk("empty_spin_active", 32'(spin_active), 32'd0);

        base = rec_idx.size();
        offer(8'h05); offer(8'h7F); offer(8'h40);
        chk("inv_count", 32'(bet_count), 32'd1);
        spin();
        give_result(1, 0);
        wait_done(t);
        chk("inv_records", 32'(rec_idx.size() - base), 32'd1);
        chk("inv_index", 32'(rec_idx[base]), 32'd0);
        chk("inv_amount", 32'(rec_amt[base]), 32'd36);

        base = rec_idx.size();
        offer(8'h68);
        spin();
        give_result(0, 0);
        wait_done(t);
        chk("even_zero_records", 32'(rec_idx.size() - base), 32'd1);
        chk("even_zero_amount", 32'(rec_amt[base]), 32'd0);

        base = rec_idx.size();
        ac = abort_cnt;
        offer(8'h41);
        spin();
        wait_done(t);
        chk("timeout_latency", 32'(t), 32'(S + T));
        chk("timeout_records", 32'(rec_idx.size() - base), 32'd0);
        chk("timeout_abort_pulse", 32'(abort_cnt - ac), 32'd1);

        offer(8'h45); offer(8'h83); offer(8'hC3); offer(8'h69);
        spin();
        give_result(0, 3);
        dc = done_cnt;
        w = 0;
        while (!(payout_valid === 1'b1 && payout_index == 4'd1) && w < 50) begin
            tick();
            w++;
        end
        chk("settle_index1_seen", 32'(payout_index), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("async_payout_valid", 32'(payout_valid), 32'd0);
        chk("async_state", 32'(state_dbg), 32'd0);
        chk("async_count", 32'(bet_count), 32'd0);
        chk("async_ready", 32'(bet_ready), 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("reset_no_done", 32'(done_cnt - dc), 32'd0);
        base = rec_idx.size();
        offer(8'hC3);
        spin();
        give_result(0, 3);
        wait_done(t);
        chk("post_reset_amount", 32'(rec_amt[base]), 32'd108);

        for (int i = 0; i < 10; i++) rand_round();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
